// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the RV32I pipeline: control-word layout, register-zero index and
// counter width, plus the write-back bypass hit test used by the ID/EX operand muxes.
package riscv_pipe_pkg;

   localparam int unsigned CTRL_W_DEFAULT = 16;
   localparam int unsigned HAZ_CNT_W      = 16;

   localparam int unsigned REG_WRITE = 0;
   localparam int unsigned MEM_READ  = 1;
   localparam int unsigned MEM_WRITE = 2;
   localparam int unsigned ALU_SRC   = 3;
   localparam int unsigned BRANCH    = 4;
   localparam int unsigned ALU_OP_LO = 8;
   localparam int unsigned ALU_OP_HI = 11;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A write-back hits a read port only for a real write to a nonzero register.
   function automatic logic wb_hits(input logic       we,
                                    input logic [4:0] waddr,
                                    input logic [4:0] raddr);
      return we && (waddr != REG_ZERO) && (waddr == raddr);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags a decode instruction that reads the
// destination of a load currently in EX. Shared with the IF/ID stage.
module load_use_detect
   import riscv_pipe_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd_addr,
   input  logic       id_valid,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   output logic       hz
);

   always_comb begin
      hz = ex_valid && ex_mem_read && (ex_rd_addr != REG_ZERO) && id_valid &&
           ((id_rs1_addr == ex_rd_addr) || (id_rs2_addr == ex_rd_addr));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
// Define WB_BYPASS_EN to forward a same-cycle write-back into the captured operands.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = CTRL_W_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 ID_VALID,
   input  logic [31:0]          ID_PC,
   input  logic [4:0]           ID_RS1_ADDR,
   input  logic [4:0]           ID_RS2_ADDR,
   input  logic [4:0]           ID_RD_ADDR,
   input  logic [31:0]          ID_DATA1,
   input  logic [31:0]          ID_DATA2,
   input  logic [31:0]          ID_IMM,
   input  logic [CTRL_W-1:0]    ID_CTRL,
   input  logic                 FLUSH,
   input  logic                 WB_WRITE_ENABLE,
   input  logic [4:0]           WB_WRITE_ADDRESS,
   input  logic [31:0]          WB_WRITE_DATA,
   output logic                 STALL,
   output logic                 EX_VALID,
   output logic [31:0]          EX_PC,
   output logic [31:0]          EX_IMM,
   output logic [31:0]          EX_DATA1,
   output logic [31:0]          EX_DATA2,
   output logic [4:0]           EX_RS1_ADDR,
   output logic [4:0]           EX_RS2_ADDR,
   output logic [4:0]           EX_RD_ADDR,
   output logic [CTRL_W-1:0]    EX_CTRL,
   output logic [HAZ_CNT_W-1:0] HAZARD_COUNT
);

`ifdef WB_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   logic                 ex_valid_q;
   logic [31:0]          ex_pc_q, ex_imm_q, ex_data1_q, ex_data2_q;
   logic [4:0]           ex_rs1_q, ex_rs2_q, ex_rd_q;
   logic [CTRL_W-1:0]    ex_ctrl_q;
   logic [HAZ_CNT_W-1:0] hazard_count_q;

   logic        hz;
   logic        stall;
   logic [31:0] op1, op2;

   load_use_detect u_load_use_detect (
      .ex_valid    (ex_valid_q),
      .ex_mem_read (ex_ctrl_q[MEM_READ]),
      .ex_rd_addr  (ex_rd_q),
      .id_valid    (ID_VALID),
      .id_rs1_addr (ID_RS1_ADDR),
      .id_rs2_addr (ID_RS2_ADDR),
      .hz          (hz)
   );

   // A flush kills the dependent instruction, so holding it upstream would be wrong.
   assign stall = hz && !FLUSH;

   always_comb begin
      op1 = ID_DATA1;
      op2 = ID_DATA2;
      if (BypassEn && wb_hits(WB_WRITE_ENABLE, WB_WRITE_ADDRESS, ID_RS1_ADDR)) begin
         op1 = WB_WRITE_DATA;
      end
      if (BypassEn && wb_hits(WB_WRITE_ENABLE, WB_WRITE_ADDRESS, ID_RS2_ADDR)) begin
         op2 = WB_WRITE_DATA;
      end
      if (ID_RS1_ADDR == REG_ZERO) op1 = '0;
      if (ID_RS2_ADDR == REG_ZERO) op2 = '0;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         ex_valid_q <= 1'b0;
         ex_pc_q    <= '0;
         ex_imm_q   <= '0;
         ex_data1_q <= '0;
         ex_data2_q <= '0;
         ex_rs1_q   <= '0;
         ex_rs2_q   <= '0;
         ex_rd_q    <= '0;
         ex_ctrl_q  <= '0;
      end else if (FLUSH || stall) begin
         // Bubble: kill valid and control, leave the datapath fields untouched.
         ex_valid_q <= 1'b0;
         ex_ctrl_q  <= '0;
      end else begin
         ex_valid_q <= ID_VALID;
         ex_pc_q    <= ID_PC;
         ex_imm_q   <= ID_IMM;
         ex_data1_q <= op1;
         ex_data2_q <= op2;
         ex_rs1_q   <= ID_RS1_ADDR;
         ex_rs2_q   <= ID_RS2_ADDR;
         ex_rd_q    <= ID_RD_ADDR;
         ex_ctrl_q  <= ID_VALID ? ID_CTRL : '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         hazard_count_q <= '0;
      end else if (stall && (hazard_count_q != {HAZ_CNT_W{1'b1}})) begin
         hazard_count_q <= hazard_count_q + 1'b1;
      end
   end

   assign STALL        = stall;
   assign EX_VALID     = ex_valid_q;
   assign EX_PC        = ex_pc_q;
   assign EX_IMM       = ex_imm_q;
   assign EX_DATA1     = ex_data1_q;
   assign EX_DATA2     = ex_data2_q;
   assign EX_RS1_ADDR  = ex_rs1_q;
   assign EX_RS2_ADDR  = ex_rs2_q;
   assign EX_RD_ADDR   = ex_rd_q;
   assign EX_CTRL      = ex_ctrl_q;
   assign HAZARD_COUNT = hazard_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use bubble, flush priority,
// write-back bypass (expectation follows WB_BYPASS_EN), x0 handling and mid-stall reset.
module tb_id_ex_stage;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ID_VALID;
   logic [31:0] ID_PC;
   logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
   logic [31:0] ID_DATA1, ID_DATA2, ID_IMM;
   logic [15:0] ID_CTRL;
   logic        FLUSH;
   logic        WB_WRITE_ENABLE;
   logic [4:0]  WB_WRITE_ADDRESS;
   logic [31:0] WB_WRITE_DATA;
   logic        STALL, EX_VALID;
   logic [31:0] EX_PC, EX_IMM, EX_DATA1, EX_DATA2;
   logic [4:0]  EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR;
   logic [15:0] EX_CTRL;
   logic [15:0] HAZARD_COUNT;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [15:0] CtrlAlu  = 16'h0001;
   localparam logic [15:0] CtrlLoad = 16'h000B;

`ifdef WB_BYPASS_EN
   localparam logic [31:0] BypassExp = 32'hDEAD;
`else
   localparam logic [31:0] BypassExp = 32'h0;
`endif

   id_ex_stage #(.CTRL_W(16)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .ID_VALID         (ID_VALID),
      .ID_PC            (ID_PC),
      .ID_RS1_ADDR      (ID_RS1_ADDR),
      .ID_RS2_ADDR      (ID_RS2_ADDR),
      .ID_RD_ADDR       (ID_RD_ADDR),
      .ID_DATA1         (ID_DATA1),
      .ID_DATA2         (ID_DATA2),
      .ID_IMM           (ID_IMM),
      .ID_CTRL          (ID_CTRL),
      .FLUSH            (FLUSH),
      .WB_WRITE_ENABLE  (WB_WRITE_ENABLE),
      .WB_WRITE_ADDRESS (WB_WRITE_ADDRESS),
      .WB_WRITE_DATA    (WB_WRITE_DATA),
      .STALL            (STALL),
      .EX_VALID         (EX_VALID),
      .EX_PC            (EX_PC),
      .EX_IMM           (EX_IMM),
      .EX_DATA1         (EX_DATA1),
      .EX_DATA2         (EX_DATA2),
      .EX_RS1_ADDR      (EX_RS1_ADDR),
      .EX_RS2_ADDR      (EX_RS2_ADDR),
      .EX_RD_ADDR       (EX_RD_ADDR),
      .EX_CTRL          (EX_CTRL),
      .HAZARD_COUNT     (HAZARD_COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [15:0] ctrl);
      ID_VALID    = v;
      ID_PC       = pc;
      ID_RS1_ADDR = rs1;
      ID_RS2_ADDR = rs2;
      ID_RD_ADDR  = rd;
      ID_DATA1    = d1;
      ID_DATA2    = d2;
      ID_CTRL     = ctrl;
      #1;
   endtask

   initial begin
      RESET            = 1'b0;
      FLUSH            = 1'b0;
      WB_WRITE_ENABLE  = 1'b0;
      WB_WRITE_ADDRESS = 5'd0;
      WB_WRITE_DATA    = 32'h0;
      ID_IMM           = 32'h1234;
      drive_id(1'b1, 32'h44, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, CtrlLoad);

      // Reset with nonzero inputs
      tick();
      tick();
      check("rst_valid", {31'b0, EX_VALID}, 32'h0);
      check("rst_pc", EX_PC, 32'h0);
      check("rst_data1", EX_DATA1, 32'h0);
      check("rst_ctrl", {16'b0, EX_CTRL}, 32'h0);
      check("rst_stall", {31'b0, STALL}, 32'h0);
      check("rst_count", {16'b0, HAZARD_COUNT}, 32'h0);
      RESET = 1'b1;

      // Pass-through
      ID_IMM = 32'h8;
      drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd4, 32'd10, 32'd20, CtrlAlu);
      check("pt_stall", {31'b0, STALL}, 32'h0);
      tick();
      check("pt_pc", EX_PC, 32'h100);
      check("pt_data1", EX_DATA1, 32'd10);
      check("pt_data2", EX_DATA2, 32'd20);
      check("pt_ctrl", {16'b0, EX_CTRL}, 32'h0001);
      check("pt_valid", {31'b0, EX_VALID}, 32'h1);
      check("pt_rd", {27'b0, EX_RD_ADDR}, 32'd4);
      check("pt_imm", EX_IMM, 32'h8);

      // Load-use: load to x5, dependent reads rs2=x5
      drive_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, CtrlLoad);
      tick();
      drive_id(1'b1, 32'h108, 5'd6, 5'd5, 5'd7, 32'h66, 32'h33, CtrlAlu);
      check("lu_stall", {31'b0, STALL}, 32'h1);
      tick();
      check("lu_bub_valid", {31'b0, EX_VALID}, 32'h0);
      check("lu_bub_ctrl", {16'b0, EX_CTRL}, 32'h0);
      check("lu_bub_pc_hold", EX_PC, 32'h104);
      check("lu_count", {16'b0, HAZARD_COUNT}, 32'd1);
      check("lu_stall_gone", {31'b0, STALL}, 32'h0);
      tick();
      check("lu_adv_pc", EX_PC, 32'h108);
      check("lu_adv_valid", {31'b0, EX_VALID}, 32'h1);
      check("lu_adv_data2", EX_DATA2, 32'h33);
      check("lu_count_hold", {16'b0, HAZARD_COUNT}, 32'd1);

      // Flush over a pending hazard
      drive_id(1'b1, 32'h10C, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, CtrlLoad);
      tick();
      FLUSH = 1'b1;
      drive_id(1'b1, 32'h110, 5'd6, 5'd5, 5'd7, 32'h66, 32'h33, CtrlAlu);
      check("fl_stall", {31'b0, STALL}, 32'h0);
      tick();
      FLUSH = 1'b0;
      check("fl_valid", {31'b0, EX_VALID}, 32'h0);
      check("fl_ctrl", {16'b0, EX_CTRL}, 32'h0);
      check("fl_pc_hold", EX_PC, 32'h10C);
      check("fl_count", {16'b0, HAZARD_COUNT}, 32'd1);

      // Invalid decode slot carries no control
      drive_id(1'b0, 32'h114, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, CtrlAlu);
      tick();
      check("inv_valid", {31'b0, EX_VALID}, 32'h0);
      check("inv_ctrl", {16'b0, EX_CTRL}, 32'h0);
      check("inv_pc", EX_PC, 32'h114);

      // Write-back bypass into rs1
      WB_WRITE_ENABLE  = 1'b1;
      WB_WRITE_ADDRESS = 5'd3;
      WB_WRITE_DATA    = 32'hDEAD;
      drive_id(1'b1, 32'h200, 5'd3, 5'd0, 5'd8, 32'h0, 32'h99, CtrlAlu);
      tick();
      check("byp_data1", EX_DATA1, BypassExp);
      check("byp_data2_x0", EX_DATA2, 32'h0);

      // x0 never forwarded or read
      WB_WRITE_ADDRESS = 5'd0;
      WB_WRITE_DATA    = 32'h77;
      drive_id(1'b1, 32'h204, 5'd0, 5'd3, 5'd9, 32'h55, 32'h12, CtrlAlu);
      tick();
      check("x0_data1", EX_DATA1, 32'h0);
      check("x0_data2", EX_DATA2, 32'h12);
      WB_WRITE_ENABLE = 1'b0;

      // Load to x0 must not stall
      drive_id(1'b1, 32'h208, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, CtrlLoad);
      tick();
      drive_id(1'b1, 32'h20C, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, CtrlAlu);
      check("x0_no_stall", {31'b0, STALL}, 32'h0);
      tick();
      check("x0_adv_pc", EX_PC, 32'h20C);
      check("x0_count", {16'b0, HAZARD_COUNT}, 32'd1);

      // Back-to-back loads, each dependent stalls once
      drive_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2, CtrlLoad);
      tick();
      drive_id(1'b1, 32'h304, 5'd8, 5'd2, 5'd9, 32'd1, 32'd2, CtrlLoad);
      check("bb_stall1", {31'b0, STALL}, 32'h1);
      tick();
      check("bb_bub1", {31'b0, EX_VALID}, 32'h0);
      tick();
      check("bb_pc1", EX_PC, 32'h304);
      drive_id(1'b1, 32'h308, 5'd9, 5'd2, 5'd10, 32'd1, 32'd2, CtrlAlu);
      check("bb_stall2", {31'b0, STALL}, 32'h1);
      tick();
      check("bb_count", {16'b0, HAZARD_COUNT}, 32'd3);
      tick();
      check("bb_pc2", EX_PC, 32'h308);

      // Reset asserted mid-stall
      drive_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, CtrlLoad);
      tick();
      drive_id(1'b1, 32'h404, 5'd11, 5'd2, 5'd12, 32'd1, 32'd2, CtrlAlu);
      check("mr_stall", {31'b0, STALL}, 32'h1);
      RESET = 1'b0;
      tick();
      check("mr_count", {16'b0, HAZARD_COUNT}, 32'h0);
      check("mr_valid", {31'b0, EX_VALID}, 32'h0);
      check("mr_pc", EX_PC, 32'h0);
      check("mr_stall_gone", {31'b0, STALL}, 32'h0);
      RESET = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
